// File: rtl/axi4_mux_w_if.sv
// AXI4 write-channel bundle (AW, W, B) used for both upstream masters and the downstream slave port.
interface axi4_mux_w_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [ID_WIDTH-1:0]     AWID;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    logic [ID_WIDTH-1:0]     BID;

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST,
        input  WREADY,
        input  BVALID, BRESP, BID,
        output BREADY
    );

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST,
        output WREADY,
        output BVALID, BRESP, BID,
        input  BREADY
    );
endinterface

// File: rtl/axi4_mux_w.sv
// Two-master AXI4 write-channel mux: latches the granted master at AW acceptance,
// regenerates WLAST from AWLEN and returns B to the owner; one transaction in flight.
module axi4_mux_w #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   m_WGRNT,
    axi4_mux_w_if.slave  s0,
    axi4_mux_w_if.slave  s1,
    axi4_mux_w_if.master m,
    output logic         busy,
    output logic         err_wlast
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [1:0]            r_sel;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_awAddr;
    logic [ID_WIDTH-1:0]   r_awId;
    logic [7:0]            r_awLen;
    logic [2:0]            r_awSize;
    logic [1:0]            r_awBurst;
    logic                  r_errWlast;

    logic w_grantOk;
    logic w_grantS1;
    logic w_selS1;
    logic w_awHs;
    logic w_wHs;
    logic w_bHs;
    logic w_cntZero;
    logic w_selWValid;
    logic w_selWLast;
    logic w_selBReady;

    assign w_grantOk   = (m_WGRNT == 2'b01) || (m_WGRNT == 2'b10);
    assign w_grantS1   = (m_WGRNT == 2'b10);
    assign w_selS1     = (r_sel == 2'b10);
    assign w_cntZero   = (r_cnt == 8'd0);
    assign w_selWValid = w_selS1 ? s1.WVALID : s0.WVALID;
    assign w_selWLast  = w_selS1 ? s1.WLAST  : s0.WLAST;
    assign w_selBReady = w_selS1 ? s1.BREADY : s0.BREADY;
    assign w_awHs      = (r_state == IDLE) && w_grantOk && (w_grantS1 ? s1.AWVALID : s0.AWVALID);
    assign w_wHs       = (r_state == DATA) && w_selWValid && m.WREADY;
    assign w_bHs       = (r_state == RESP) && m.BVALID && w_selBReady;
    assign busy        = (r_state != IDLE);
    assign err_wlast   = r_errWlast;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_awHs) w_nextState = ADDR;
            ADDR:    if (m.AWREADY) w_nextState = DATA;
            DATA:    if (w_wHs && w_cntZero) w_nextState = RESP;
            RESP:    if (w_bHs) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Ownership and the beat counter only change on handshakes; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel      <= 2'b00;
            r_cnt      <= 8'd0;
            r_awAddr   <= '0;
            r_awId     <= '0;
            r_awLen    <= 8'd0;
            r_awSize   <= 3'd0;
            r_awBurst  <= 2'd0;
            r_errWlast <= 1'b0;
        end else begin
            if (w_awHs) begin
                r_sel     <= m_WGRNT;
                r_cnt     <= w_grantS1 ? s1.AWLEN   : s0.AWLEN;
                r_awAddr  <= w_grantS1 ? s1.AWADDR  : s0.AWADDR;
                r_awId    <= w_grantS1 ? s1.AWID    : s0.AWID;
                r_awLen   <= w_grantS1 ? s1.AWLEN   : s0.AWLEN;
                r_awSize  <= w_grantS1 ? s1.AWSIZE  : s0.AWSIZE;
                r_awBurst <= w_grantS1 ? s1.AWBURST : s0.AWBURST;
            end
            if (w_wHs) begin
                if (!w_cntZero) r_cnt <= r_cnt - 8'd1;
                if (w_selWLast != w_cntZero) r_errWlast <= 1'b1;
            end
            if (w_bHs) r_sel <= 2'b00;
        end
    end

    always_comb begin
        s0.AWREADY = 1'b0;
        s1.AWREADY = 1'b0;
        s0.WREADY  = 1'b0;
        s1.WREADY  = 1'b0;
        s0.BVALID  = 1'b0;
        s1.BVALID  = 1'b0;
        s0.BRESP   = 2'b00;
        s1.BRESP   = 2'b00;
        s0.BID     = '0;
        s1.BID     = '0;
        m.AWVALID  = (r_state == ADDR);
        m.AWADDR   = r_awAddr;
        m.AWID     = r_awId;
        m.AWLEN    = r_awLen;
        m.AWSIZE   = r_awSize;
        m.AWBURST  = r_awBurst;
        m.WVALID   = 1'b0;
        m.WDATA    = w_selS1 ? s1.WDATA : s0.WDATA;
        m.WSTRB    = w_selS1 ? s1.WSTRB : s0.WSTRB;
        m.WLAST    = 1'b0;
        m.BREADY   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grantOk) begin
                    s0.AWREADY = m_WGRNT[0];
                    s1.AWREADY = m_WGRNT[1];
                end
            end
            DATA: begin
                m.WVALID = w_selWValid;
                m.WLAST  = w_cntZero;
                if (w_selS1) s1.WREADY = m.WREADY;
                else         s0.WREADY = m.WREADY;
            end
            RESP: begin
                m.BREADY = w_selBReady;
                if (w_selS1) begin
                    s1.BVALID = m.BVALID;
                    s1.BRESP  = m.BRESP;
                    s1.BID    = m.BID;
                end else begin
                    s0.BVALID = m.BVALID;
                    s0.BRESP  = m.BRESP;
                    s0.BID    = m.BID;
                end
            end
            default: ;
        endcase
    end
endmodule
